// File: rtl/rotate_ram_bridge.sv
// rotate_ram_bridge: serialises vidin_* 16-word write bursts and vidout_* 8-word read bursts onto the single-word ram_* req/ack port, reads winning ties
module rotate_ram_bridge #(
  parameter int ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE = 24'h100000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  vidin_req,
  input  logic                  vidin_frame,
  input  logic [9:0]            vidin_row,
  input  logic [9:0]            vidin_col,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic                  vidout_frame,
  input  logic [9:0]            vidout_row,
  input  logic [9:0]            vidout_col,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_wd,
  input  logic                  ram_ack,
  input  logic [15:0]           ram_rd
);
  typedef enum logic [2:0] {IDLE, WR_LOAD, WR_WAIT, WR_GAP, RD, REARM} state_t;
  state_t r_state, w_state_nxt;
  logic                  r_rd, r_frame, w_rd_nxt, w_frame_nxt;
  logic [9:0]            r_row, r_col, w_row_nxt, w_col_nxt;
  logic [3:0]            r_idx, w_idx_nxt, w_idx_inc;
  logic                  r_ram_req, r_ram_we, r_vidin_ack, r_vidout_ack;
  logic                  w_ram_req_nxt, w_ram_we_nxt, w_vidin_ack_nxt, w_vidout_ack_nxt;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [15:0]           r_ram_wd, r_vidout_d, w_ram_wd_nxt, w_vidout_d_nxt;
  logic                  w_last;
  logic [20:0]           w_off_cap, w_off_rd_new;
  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [20:0] off);
    return RAM_BASE + ADDR_WIDTH'(off);
  endfunction
  assign w_last       = r_rd ? r_idx == 4'd7 : r_idx == 4'd15;
  assign w_idx_inc    = r_idx + 4'd1;
  assign w_off_cap    = {r_frame, r_row, r_col};
  assign w_off_rd_new = {vidout_frame, vidout_row, vidout_col & 10'h3F8};
  always_ff @(posedge clk_sys)
    r_state <= reset ? IDLE : w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = vidout_req ? RD : vidin_req ? WR_LOAD : IDLE;
      WR_LOAD: w_state_nxt = WR_WAIT;
      WR_WAIT: w_state_nxt = !ram_ack ? WR_WAIT : w_last ? REARM : WR_GAP;
      WR_GAP:  w_state_nxt = WR_LOAD;
      RD:      w_state_nxt = (ram_ack && w_last) ? REARM : RD;
      REARM:   w_state_nxt = (r_rd ? vidout_req : vidin_req) ? REARM : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_rd_nxt         = r_rd;
    w_frame_nxt      = r_frame;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_idx_nxt        = r_idx;
    w_ram_req_nxt    = r_ram_req;
    w_ram_we_nxt     = r_ram_we;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_wd_nxt     = r_ram_wd;
    w_vidout_d_nxt   = r_vidout_d;
    w_vidin_ack_nxt  = 1'b0;
    w_vidout_ack_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_idx_nxt = 4'd0;
        if (vidout_req) begin
          w_rd_nxt       = 1'b1;
          w_frame_nxt    = vidout_frame;
          w_row_nxt      = vidout_row;
          w_col_nxt      = vidout_col & 10'h3F8;
          w_ram_req_nxt  = 1'b1;
          w_ram_we_nxt   = 1'b0;
          w_ram_addr_nxt = f_addr(w_off_rd_new);
        end else if (vidin_req) begin
          w_rd_nxt    = 1'b0;
          w_frame_nxt = vidin_frame;
          w_row_nxt   = vidin_row;
          w_col_nxt   = vidin_col & 10'h3F0;
        end
      end
      WR_LOAD: begin
        w_ram_wd_nxt   = vidin_d;
        w_ram_addr_nxt = f_addr(w_off_cap | 21'(r_idx));
        w_ram_req_nxt  = 1'b1;
        w_ram_we_nxt   = 1'b1;
      end
      WR_WAIT: begin
        if (ram_ack) begin
          w_ram_req_nxt   = 1'b0;
          w_vidin_ack_nxt = 1'b1;
          w_idx_nxt       = w_last ? r_idx : w_idx_inc;
        end
      end
      RD: begin
        if (ram_ack) begin
          w_vidout_d_nxt   = ram_rd;
          w_vidout_ack_nxt = 1'b1;
          w_ram_req_nxt    = !w_last;
          w_idx_nxt        = w_last ? r_idx : w_idx_inc;
          w_ram_addr_nxt   = w_last ? r_ram_addr : f_addr(w_off_cap | 21'(w_idx_inc));
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rd         <= 1'b0;
      r_frame      <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_idx        <= '0;
      r_ram_req    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wd     <= '0;
      r_vidout_d   <= '0;
      r_vidin_ack  <= 1'b0;
      r_vidout_ack <= 1'b0;
    end else begin
      r_rd         <= w_rd_nxt;
      r_frame      <= w_frame_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_idx        <= w_idx_nxt;
      r_ram_req    <= w_ram_req_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_wd     <= w_ram_wd_nxt;
      r_vidout_d   <= w_vidout_d_nxt;
      r_vidin_ack  <= w_vidin_ack_nxt;
      r_vidout_ack <= w_vidout_ack_nxt;
    end
  end
  assign ram_req    = r_ram_req;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wd     = r_ram_wd;
  assign vidout_d   = r_vidout_d;
  assign vidin_ack  = r_vidin_ack;
  assign vidout_ack = r_vidout_ack;
endmodule

// File: tb/tb_rotate_ram_bridge.sv
// tb_rotate_ram_bridge: directed burst vectors plus arbitration, reset-abort and rearm sequences
module tb_rotate_ram_bridge;
  localparam logic [23:0] BASE = 24'h100000;
  typedef struct {
    bit          rd;
    logic        frame;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [20:0] off;
    int          dly;
  } vec_t;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        vidin_req = 1'b0, vidin_frame = 1'b0, vidout_req = 1'b0, vidout_frame = 1'b0;
  logic [9:0]  vidin_row = '0, vidin_col = '0, vidout_row = '0, vidout_col = '0;
  logic [15:0] vidin_d = '0, ram_rd = '0;
  logic        ram_ack = 1'b0;
  logic        vidin_ack, vidout_ack, ram_req, ram_we;
  logic [15:0] vidout_d, ram_wd;
  logic [23:0] ram_addr;
  int          n_chk = 0, n_fail = 0;
  int          n_acc = 0, n_vin = 0, n_vo = 0, n_both = 0, cyc = 0, cnt = 0;
  int          ack_dly = 1;
  bit          ram_ack_en = 1'b0, stray = 1'b0, last_rd_ack = 1'b0;
  logic [23:0] acc_addr [512];
  logic [15:0] acc_wd [512];
  logic        acc_we [512];
  int          acc_cyc [512];
  logic [15:0] vo_d [512];
  bit          vo_lat [512];
  vec_t        vecs [5];
  rotate_ram_bridge dut (
    .clk_sys(clk_sys), .reset(reset),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row), .vidin_col(vidin_col),
    .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row), .vidout_col(vidout_col),
    .vidout_d(vidout_d), .vidout_ack(vidout_ack),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_ack(ram_ack), .ram_rd(ram_rd)
  );
  always #5 clk_sys = ~clk_sys;
  initial forever begin
    @(negedge clk_sys);
    cyc++;
    if (vidin_ack === 1'b1) n_vin++;
    if (vidout_ack === 1'b1 && n_vo < 512) begin
      vo_d[n_vo]   = vidout_d;
      vo_lat[n_vo] = last_rd_ack;
      n_vo++;
    end
    if (vidin_ack === 1'b1 && vidout_ack === 1'b1) n_both++;
    last_rd_ack = 1'b0;
    ram_ack = stray;
    if (ram_ack_en && ram_req === 1'b1 && n_acc < 512) begin
      cnt++;
      if (cnt >= ack_dly) begin
        cnt             = 0;
        ram_ack         = 1'b1;
        ram_rd          = ram_addr[15:0];
        acc_addr[n_acc] = ram_addr;
        acc_wd[n_acc]   = ram_wd;
        acc_we[n_acc]   = ram_we;
        acc_cyc[n_acc]  = cyc;
        last_rd_ack     = !ram_we;
        n_acc++;
      end
    end else cnt = 0;
    vidin_d = 16'hD000 + 16'(n_vin);
  end
  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_acc(input int a0, input int n);
    int g = 0;
    while (n_acc - a0 < n && g < 600) begin
      step();
      g++;
    end
    chk("burst_timeout", 32'(n_acc - a0 >= n), 32'd1);
  endtask
  task automatic run_burst(input vec_t v);
    int a0, vi0, vo0, n;
    logic [23:0] ea;
    logic [15:0] ed;
    n = v.rd ? 8 : 16;
    step();
    a0 = n_acc; vi0 = n_vin; vo0 = n_vo;
    ack_dly = v.dly;
    ram_ack_en = 1'b1;
    if (v.rd) begin
      vidout_frame = v.frame; vidout_row = v.row; vidout_col = v.col; vidout_req = 1'b1;
    end else begin
      vidin_frame = v.frame; vidin_row = v.row; vidin_col = v.col; vidin_req = 1'b1;
    end
    wait_acc(a0, n);
    repeat (6) step();
    chk("rearm_no_new_burst", 32'(n_acc - a0), 32'(n));
    chk("rearm_req_low", 32'(ram_req), 32'd0);
    vidin_req = 1'b0;
    vidout_req = 1'b0;
    repeat (3) step();
    chk(v.rd ? "vidout_ack_count" : "vidin_ack_count", 32'(v.rd ? n_vo - vo0 : n_vin - vi0), 32'(n));
    chk("other_ack_count", 32'(v.rd ? n_vin - vi0 : n_vo - vo0), 32'd0);
    for (int k = 0; k < n; k++) begin
      ea = BASE + 24'(v.off | 21'(k));
      chk("addr", 32'(acc_addr[a0 + k]), 32'(ea));
      chk("we", 32'(acc_we[a0 + k]), 32'(!v.rd));
      if (k > 0) chk("spacing", 32'(acc_cyc[a0 + k] - acc_cyc[a0 + k - 1]), 32'(v.rd ? v.dly : v.dly + 2));
      if (v.rd) begin
        chk("vidout_d", 32'(vo_d[vo0 + k]), 32'(ea[15:0]));
        chk("vidout_latency", 32'(vo_lat[vo0 + k]), 32'd1);
      end else begin
        ed = 16'hD000 + 16'(vi0 + k);
        chk("ram_wd", 32'(acc_wd[a0 + k]), 32'(ed));
      end
    end
    chk("both_acks", 32'(n_both), 32'd0);
  endtask
  initial begin
    int a0, vi0, vo0, g;
    vec_t vb;
    vecs[0] = '{rd: 1'b0, frame: 1'b0, row: 10'd3,   col: 10'h020, off: 21'h000C20, dly: 2};
    vecs[1] = '{rd: 1'b1, frame: 1'b1, row: 10'h3FF, col: 10'h3F8, off: 21'h1FFFF8, dly: 1};
    vecs[2] = '{rd: 1'b0, frame: 1'b1, row: 10'd5,   col: 10'h013, off: 21'h101410, dly: 1};
    vecs[3] = '{rd: 1'b1, frame: 1'b0, row: 10'd2,   col: 10'h005, off: 21'h000800, dly: 3};
    vecs[4] = '{rd: 1'b1, frame: 1'b0, row: 10'd0,   col: 10'h000, off: 21'h000000, dly: 1};
    vb      = '{rd: 1'b0, frame: 1'b0, row: 10'd9,   col: 10'h040, off: 21'h002440, dly: 2};
    repeat (3) step();
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_vidin_ack", 32'(vidin_ack), 32'd0);
    chk("rst_vidout_ack", 32'(vidout_ack), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wd", 32'(ram_wd), 32'd0);
    chk("rst_vidout_d", 32'(vidout_d), 32'd0);
    reset = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 5; i++) run_burst(vecs[i]);
    step();
    a0 = n_acc;
    ack_dly = 1;
    ram_ack_en = 1'b1;
    vidin_frame = 1'b0; vidin_row = 10'd1; vidin_col = 10'h000;
    vidout_frame = 1'b0; vidout_row = 10'd7; vidout_col = 10'h008;
    vidin_req = 1'b1;
    vidout_req = 1'b1;
    wait_acc(a0, 8);
    vidout_req = 1'b0;
    wait_acc(a0, 24);
    vidin_req = 1'b0;
    repeat (4) step();
    chk("arb_total", 32'(n_acc - a0), 32'd24);
    for (int k = 0; k < 24; k++) begin
      chk("arb_we", 32'(acc_we[a0 + k]), 32'(k >= 8));
      chk("arb_addr", 32'(acc_addr[a0 + k]),
          32'(k < 8 ? BASE + 24'(21'h001C08 | 21'(k)) : BASE + 24'(21'h000400 | 21'(k - 8))));
    end
    a0 = n_acc; vi0 = n_vin; vo0 = n_vo;
    ack_dly = 2;
    vidin_frame = vb.frame; vidin_row = vb.row; vidin_col = vb.col;
    vidin_req = 1'b1;
    g = 0;
    while (!(n_acc - a0 == 4 && ram_req === 1'b1 && ram_ack == 1'b0) && g < 300) begin
      step();
      g++;
    end
    chk("fifth_word_timeout", 32'(g < 300), 32'd1);
    reset = 1'b1;
    ram_ack_en = 1'b0;
    step();
    chk("abort_ram_req", 32'(ram_req), 32'd0);
    chk("abort_vidin_ack", 32'(vidin_ack), 32'd0);
    vidin_req = 1'b0;
    step();
    reset = 1'b0;
    stray = 1'b1;
    repeat (2) step();
    stray = 1'b0;
    repeat (3) step();
    chk("stray_ram_req", 32'(ram_req), 32'd0);
    chk("abort_vidin_acks", 32'(n_vin - vi0), 32'd4);
    chk("stray_vidout_acks", 32'(n_vo - vo0), 32'd0);
    run_burst(vb);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rotate_ram_bridge.md
Name: rotate_ram_bridge

Overview:
- Services the rotation framebuffer memory ports of the scandoubler.
- Takes 16-word write bursts (vidin_*) and 8-word read bursts (vidout_*) and serialises them onto one word-wide RAM request/ack port (ram_*).
- Arbitrates between the two at burst boundaries and computes linear RAM addresses from frame/row/col.
- Sits between the scandoubler rotation path and the SDRAM controller's video port.

Parameters:
ADDR_WIDTH, 24, width of ram_addr in 16-bit words.
RAM_BASE, 24'h100000, word address of frame 0, row 0, col 0; added to the computed offset modulo 2^ADDR_WIDTH.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
vidin_req  in  1  write burst request from scandoubler.
vidin_frame  in  1  write framebuffer select.
vidin_row  in  10  write row.
vidin_col  in  10  write column; bits [3:0] ignored (forced 0).
vidin_d  in  16  write data word.
vidin_ack  out  1  one-cycle pulse: current word consumed, present next.
vidout_req  in  1  read burst request.
vidout_frame  in  1  read framebuffer select.
vidout_row  in  10  read row.
vidout_col  in  10  read column; bits [2:0] ignored (forced 0).
vidout_d  out  16  read data, valid when vidout_ack high.
vidout_ack  out  1  one-cycle pulse per read word.
ram_req  out  1  RAM word request; level, held until ram_ack.
ram_we  out  1  1 = write, 0 = read; stable while ram_req high.
ram_addr  out  ADDR_WIDTH  word address; stable while ram_req high.
ram_wd  out  16  write data; stable while ram_req high.
ram_ack  in  1  one-cycle pulse completing the current word.
ram_rd  in  16  read data, valid in the ram_ack cycle.

Behaviour:
- Reset:
  - state=IDLE; ram_req, ram_we, vidin_ack, vidout_ack = 0; ram_addr, ram_wd, vidout_d = 0; word index = 0.
  - Reset mid-burst aborts immediately: ram_req low the next cycle, no further acks.
  - Any ram_ack arriving while in IDLE or REARM is ignored.
- Address: offset = {frame, row, col_aligned}, 21 bits, with the burst word index ORed into the low bits (4 bits write, 3 bits read), so no carry. ram_addr = RAM_BASE + zero-extended offset.
- Request capture: frame/row/col are sampled in IDLE on the cycle a burst is granted and held for the whole burst.
- Arbitration (IDLE only): vidout_req has fixed priority over vidin_req. No preemption mid-burst.
- States:
  - IDLE: if vidout_req -> RD (ram_req=1, ram_we=0, idx=0); else if vidin_req -> WR_LOAD.
  - WR_LOAD: latch vidin_d into ram_wd, set ram_addr, ram_req=1, ram_we=1 -> WR_WAIT.
  - WR_WAIT: hold until ram_ack. On ram_ack: ram_req=0, vidin_ack=1 for the next cycle.
    - If idx==15 -> REARM (vidin_ack still pulses).
    - Else idx++ -> WR_GAP.
  - WR_GAP: vidin_ack high this cycle; host updates vidin_d by the next edge -> WR_LOAD.
  - RD: ram_req held high. On ram_ack: vidout_d<=ram_rd and vidout_ack=1 on the next cycle (latency 1).
    - If idx==7: ram_req=0 -> REARM.
    - Else idx++, ram_addr advances the same edge and ram_req stays high (back-to-back words allowed).
  - REARM: wait until the serviced request line (vidin_req for write bursts, vidout_req for read bursts) is sampled low -> IDLE. A new burst always needs req low for at least 1 cycle.
- Write word throughput: at most 1 word per 3 cycles. Read: 1 word per cycle if RAM acks continuously.
- Exactly 16 vidin_ack pulses per write burst and 8 vidout_ack pulses per read burst; never both acks high together.
- Input request toggling mid-burst does not affect the burst in progress.

Test Plan:
- Reset then vidin_req=1, frame=0, row=3, col=32, RAM acks 2 cycles after req -> 16 writes to RAM_BASE+0x0C20..0x0C2F with ram_wd equal to successive vidin_d words; exactly 16 vidin_ack pulses; then REARM until req low.
- vidout_req=1, frame=1, row=0x3FF, col=0x3F8, ram_ack every cycle with ram_rd=addr[15:0] -> addresses RAM_BASE+0x1FFFF8..0x1FFFFF, vidout_ack on 8 consecutive cycles each 1 cycle after ram_ack, vidout_d matching.
- vidin_req and vidout_req rise on the same cycle -> read burst served first (8 reads), write burst starts only after read REARM and IDLE.
- Unaligned cols: vidin_col=0x013, vidout_col=0x005 -> bursts start at col 0x010 and 0x000 respectively.
- Assert reset during the 5th write word with ram_req high -> ram_req low next cycle, vidin_ack stays 0; a stray ram_ack afterwards causes no ack; a fresh burst after reset starts at idx 0.
- vidin_req held high after the 16th ack -> no second burst until req has been low for at least 1 cycle.
